// File: rtl/metric_min_select.sv
// Streaming arg-min / arg-max selector: collects a group of up to N_CAND unsigned
// metrics and holds the winning metric, its position and the group size until taken.
module metric_min_select #(
  parameter int W      = 8,
  parameter int N_CAND = 4,
  parameter int MODE   = 0,
  localparam int IW    = (N_CAND <= 2) ? 1 : $clog2(N_CAND)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_metric,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_metric,
  output logic [IW-1:0] out_idx,
  output logic [IW:0]   out_cnt
);

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

  localparam logic          MAX_SEL  = (MODE == 1);
  localparam logic [IW:0]   LAST_CNT = (IW+1)'(N_CAND - 1);

  state_t        state_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [W-1:0]  out_metric_q;
  logic [IW-1:0] out_idx_q;
  logic [IW:0]   out_cnt_q;
  logic [IW:0]   cnt_q;
  logic [W-1:0]  best_metric_q;
  logic [IW-1:0] best_idx_q;

  logic [W-1:0]  diff_d;
  logic          borrow_d;
  logic          take_d;
  logic          close_d;
  logic [W-1:0]  win_metric_d;
  logic [IW-1:0] win_idx_d;
  logic [IW:0]   cnt_inc_d;

  // Ripple-borrow subtract in_metric - best_metric; only the borrow-out orders the pair.
  always_comb begin
    logic brw;
    brw    = 1'b0;
    diff_d = '0;
    for (int i = 0; i < W; i++) begin
      diff_d[i] = in_metric[i] ^ best_metric_q[i] ^ brw;
      brw = (~in_metric[i] & best_metric_q[i]) |
            (~(in_metric[i] ^ best_metric_q[i]) & brw);
    end
    borrow_d = brw;
  end

  always_comb begin
    take_d       = (cnt_q == '0) ||
                   (MAX_SEL ? (!borrow_d && (|diff_d)) : borrow_d);
    close_d      = in_last || (cnt_q == LAST_CNT);
    win_metric_d = take_d ? in_metric : best_metric_q;
    win_idx_d    = take_d ? cnt_q[IW-1:0] : best_idx_q;
    cnt_inc_d    = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ACC;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_metric_q  <= '0;
      out_idx_q     <= '0;
      out_cnt_q     <= '0;
      cnt_q         <= '0;
      best_metric_q <= '0;
      best_idx_q    <= '0;
    end else begin
      case (state_q)
        ACC: begin
          if (in_valid) begin
            if (close_d) begin
              out_metric_q  <= win_metric_d;
              out_idx_q     <= win_idx_d;
              out_cnt_q     <= cnt_inc_d;
              out_valid_q   <= 1'b1;
              in_ready_q    <= 1'b0;
              state_q       <= HOLD;
              cnt_q         <= '0;
              best_metric_q <= '0;
              best_idx_q    <= '0;
            end else begin
              cnt_q         <= cnt_inc_d;
              best_metric_q <= win_metric_d;
              best_idx_q    <= win_idx_d;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ACC;
            cnt_q       <= '0;
          end
        end
        default: begin
          state_q    <= ACC;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_metric = out_metric_q;
  assign out_idx    = out_idx_q;
  assign out_cnt    = out_cnt_q;

endmodule

// File: tb/tb_metric_min_select.sv
// Bench for metric_min_select: a MODE=0 and a MODE=1 instance share one stimulus stream
// and are checked every cycle against a group-list model, plus literal scenario checks.
module tb_metric_min_select;

  localparam int W  = 8;
  localparam int NC = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_metric = '0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;

  logic          in_ready0, in_ready1;
  logic          out_valid0, out_valid1;
  logic [W-1:0]  out_metric0, out_metric1;
  logic [IW-1:0] out_idx0, out_idx1;
  logic [IW:0]   out_cnt0, out_cnt1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  metric_min_select #(.W(W), .N_CAND(NC), .MODE(0)) dut_min (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_metric(in_metric), .in_last(in_last), .out_valid(out_valid0),
    .out_ready(out_ready), .out_metric(out_metric0), .out_idx(out_idx0),
    .out_cnt(out_cnt0)
  );

  metric_min_select #(.W(W), .N_CAND(NC), .MODE(1)) dut_max (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_metric(in_metric), .in_last(in_last), .out_valid(out_valid1),
    .out_ready(out_ready), .out_metric(out_metric1), .out_idx(out_idx1),
    .out_cnt(out_cnt1)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end else begin
      $display("ok   %s = %0d", nm, act);
    end
  endtask

  // Group-level model: keep the accepted metrics of the open group, pick the winner on close.
  bit m_on = 0;
  bit m_hold = 0;
  int grp[$];
  int m_min, m_min_idx, m_max, m_max_idx, m_cnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_on = 1;
      m_hold = 0;
      grp.delete();
    end else if (m_on) begin
      if (m_hold) begin
        if (out_ready) begin
          m_hold = 0;
          grp.delete();
        end
      end else if (in_valid) begin
        grp.push_back(int'(in_metric));
        if (in_last || grp.size() == NC) begin
          m_min_idx = 0;
          m_max_idx = 0;
          foreach (grp[i]) begin
            if (grp[i] < grp[m_min_idx]) m_min_idx = i;
            if (grp[i] > grp[m_max_idx]) m_max_idx = i;
          end
          m_min  = grp[m_min_idx];
          m_max  = grp[m_max_idx];
          m_cnt  = grp.size();
          m_hold = 1;
        end
      end
    end
  end

  task automatic cmp_cycle(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_on && rst_n) begin
      cmp_cycle("in_ready_min", in_ready0, !m_hold);
      cmp_cycle("in_ready_max", in_ready1, !m_hold);
      cmp_cycle("out_valid_min", out_valid0, m_hold);
      cmp_cycle("out_valid_max", out_valid1, m_hold);
      if (m_hold) begin
        cmp_cycle("out_metric_min", out_metric0, m_min);
        cmp_cycle("out_idx_min", out_idx0, m_min_idx);
        cmp_cycle("out_cnt_min", out_cnt0, m_cnt);
        cmp_cycle("out_metric_max", out_metric1, m_max);
        cmp_cycle("out_idx_max", out_idx1, m_max_idx);
        cmp_cycle("out_cnt_max", out_cnt1, m_cnt);
      end
    end
  end

  // Present one candidate and return #1 after the edge that accepted it.
  task automatic send(input int m, input bit last);
    int k;
    in_valid  = 1'b1;
    in_metric = W'(m);
    in_last   = last;
    k = 0;
    while (!in_ready0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 200) chk("send_timeout", 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    $display("sent metric=%0d last=%0d", m, last);
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", in_ready0, 1);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_out_metric", out_metric0, 0);
    chk("rst_out_idx", out_idx0, 0);
    chk("rst_out_cnt", out_cnt0, 0);

    // Minimum with a tie: 40,17,17,90
    send(40, 0); send(17, 0); send(17, 0); send(90, 1);
    chk("g1_valid_lat1", out_valid0, 1);
    chk("g1_min_metric", out_metric0, 17);
    chk("g1_min_idx", out_idx0, 1);
    chk("g1_min_cnt", out_cnt0, 4);
    chk("g1_max_metric", out_metric1, 90);
    chk("g1_max_idx", out_idx1, 3);
    take_result();

    // Maximum with a tie: 3,255,255
    send(3, 0); send(255, 0); send(255, 1);
    chk("g2_max_metric", out_metric1, 255);
    chk("g2_max_idx", out_idx1, 1);
    chk("g2_max_cnt", out_cnt1, 3);
    chk("g2_min_metric", out_metric0, 3);
    chk("g2_min_idx", out_idx0, 0);
    take_result();

    // Single candidate, then a stalled consumer
    send(8'h80, 1);
    chk("g3_valid_lat1", out_valid0, 1);
    chk("g3_metric", out_metric0, 8'h80);
    chk("g3_idx", out_idx0, 0);
    chk("g3_cnt", out_cnt0, 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid0, 1);
      chk("hold_metric", out_metric0, 8'h80);
      chk("hold_in_ready", in_ready0, 0);
    end
    take_result();
    chk("release_in_ready", in_ready0, 1);
    chk("release_out_valid", out_valid0, 0);

    // Six candidates without in_last: closes on the 4th, 5th waits for release
    send(5, 0); send(4, 0); send(3, 0); send(2, 0);
    chk("g4_valid", out_valid0, 1);
    chk("g4_min_metric", out_metric0, 2);
    chk("g4_min_idx", out_idx0, 3);
    chk("g4_cnt", out_cnt0, 4);
    fork
      send(1, 0);
      begin
        repeat (3) begin
          @(posedge clk); #1;
          chk("g4_wait_in_ready", in_ready0, 0);
        end
        take_result();
      end
    join
    send(0, 0); send(9, 1);
    chk("g5_min_metric", out_metric0, 0);
    chk("g5_min_idx", out_idx0, 1);
    chk("g5_cnt", out_cnt0, 3);
    take_result();

    // Reset mid-group discards the partial group
    send(10, 0); send(20, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_out_valid", out_valid0, 0);
    chk("midrst_in_ready", in_ready0, 1);
    send(50, 0); send(30, 1);
    chk("g6_min_metric", out_metric0, 30);
    chk("g6_min_idx", out_idx0, 1);
    chk("g6_cnt", out_cnt0, 2);
    take_result();

    // Random traffic, checked by the cycle model
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst_n     = ($urandom_range(0, 299) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_metric = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 7)) : W'($urandom);
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) == 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
